fifo16_sync_buffer: RTL and testbench
=====================================

Name: fifo16_sync_buffer

Overview:
- Single-clock circular FIFO buffering a 16-bit data stream between a producer and a slower consumer.
- The consumer is throttled by its own read enable, e.g. one read request every 4 clocks.
- Exposes the raw extended read and write pointers for debug and occupancy monitoring.
- Sits between a data source (write side) and a downstream consumer (read side).

Parameters:
- DATA_W, 16, width of data_in and data_out.
- ADDR_W, 4, storage address width; depth = 2**ADDR_W = 16 entries; pointers are ADDR_W+1 = 5 bits.

Ports:
- wr_clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds 2**ADDR_W entries.
- wr_ptr  out  ADDR_W+1  extended write pointer (MSB = wrap bit).
- rd_ptr  out  ADDR_W+1  extended read pointer (MSB = wrap bit).

Behaviour:
- Reset (reset=0, asynchronous, independent of wr_clk):
  - wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0.
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all queued entries immediately.
- Flags are combinational from the pointer registers:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
- Write accept = wr_en && !full, using the pre-edge full.
  - On accept: mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr <= wr_ptr+1, wrapping mod 2**(ADDR_W+1).
  - Write while full is silently dropped; wr_ptr unchanged.
- Read accept = rd_en && !empty, using the pre-edge empty.
  - On accept: data_out <= mem[rd_ptr[ADDR_W-1:0]]; rd_ptr <= rd_ptr+1 (wraps).
  - Latency: data visible on data_out one clock after the accepting edge.
  - data_out holds its last value when no read is accepted, including reads while empty; rd_ptr is unchanged on a rejected read.
- Simultaneous wr_en and rd_en:
  - Each is evaluated independently against the pre-edge flags.
  - When full: the read is accepted and the write is dropped.
  - When empty: the write is accepted and the read is dropped (no bypass).
  - Otherwise both are accepted and occupancy is unchanged.
- Occupancy = wr_ptr - rd_ptr (mod 32), always in 0..16.
- No X propagation: data_out never shows an uninitialised location, because empty blocks reads.

Optional Feature:
- Macro FIFO16_ERR_FLAGS_EN.
- Defined:
  - Adds output overflow (1 bit): sticky, set on a cycle with wr_en && full.
  - Adds output underflow (1 bit): sticky, set on a cycle with rd_en && empty.
  - Both clear only on reset, and both reset to 0.
- Undefined: these ports and their logic do not exist; illegal requests are still silently dropped.

Decomposition:
- Package fifo16_pkg holds:
  - Constants DATA_W=16, ADDR_W=4, DEPTH=16, PTR_W=5.
  - A typedef for the data word and for the extended pointer.
- One natural sub-module, fifo16_ram: 16x16 storage array.
  - One synchronous write port (we, waddr, wdata).
  - One synchronous read port (re, raddr, rdata registered).
  - No reset on the array.
- Top level holds pointers, flags and the optional error flags.

Test Plan:
- Reset: drive reset=0 mid-stream with 5 entries queued -> immediately wr_ptr=0, rd_ptr=0, empty=1, full=0, data_out=0.
- Fill: 16 consecutive writes of 0x0001..0x0010, rd_en=0 -> full=1 after 16th edge, wr_ptr=5'b10000; a 17th write (0x0011) is dropped and wr_ptr stays 5'b10000.
- Drain: then 16 reads -> data_out sequence 0x0001..0x0010, each one clock after its accepting edge; empty=1 after the last read, rd_ptr=5'b10000; an extra read leaves data_out=0x0010.
- Rate mismatch: write every clock, read every 4th clock, for 40 clocks -> FIFO reaches full; all accepted words emerge in order with no duplicates; dropped words are exactly those presented while full.
- Simultaneous: with 8 entries, wr_en=rd_en=1 for 20 clocks -> occupancy stays 8; pointers wrap 31->0 without glitching empty or full.
- Boundary simultaneous: when full with wr_en=rd_en=1 -> only the read is accepted (occupancy 15); when empty with both high -> only the write is accepted (occupancy 1, data_out unchanged). With FIFO16_ERR_FLAGS_EN defined, the full/wr_en and empty/rd_en cases set overflow and underflow respectively, and both stay set until reset.

Source files
------------

// File: rtl/fifo16_pkg.sv
// Shared constants and types for the 16-entry single-clock FIFO.
package fifo16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PTR_W-1:0]  ptr_t;

endpackage

// File: rtl/fifo16_ram.sv
// 16x16 storage with one synchronous write port and one registered read port.
module fifo16_ram
    import fifo16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  data_t             wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output data_t             rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is cleared; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo16_sync_buffer.sv
// Single-clock 16-deep circular FIFO with extended pointers exposed for debug.
// Optional sticky overflow/underflow outputs are built when FIFO16_ERR_FLAGS_EN is defined.
module fifo16_sync_buffer
    import fifo16_pkg::*;
(
    input  logic              wr_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [PTR_W-1:0]  rd_ptr
`ifdef FIFO16_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    ptr_t wr_ptr_q;
    ptr_t rd_ptr_q;
    logic wr_acc;
    logic rd_acc;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    fifo16_ram u_ram (
        .clk   (wr_clk),
        .rst_n (reset),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (data_out)
    );

`ifdef FIFO16_ERR_FLAGS_EN
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo16_sync_buffer.sv
// Bench for fifo16_sync_buffer: vector table for the basic flow plus a queue model
// with a read-data scoreboard for fill/drain, rate mismatch, wrap and boundary cases.
module tb_fifo16_sync_buffer;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        empty;
    logic        full;
    logic [4:0]  wr_ptr;
    logic [4:0]  rd_ptr;
`ifdef FIFO16_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    fifo16_sync_buffer dut (
        .wr_clk   (wr_clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr)
`ifdef FIFO16_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    logic [4:0]  ewp;
    logic [4:0]  erp;
    logic [15:0] last_out;
    logic        eov;
    logic        euf;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] d;
        logic        emp;
        logic        ful;
        logic [4:0]  wp;
        logic [4:0]  rp;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one clock of requests; the model decides acceptance from its own occupancy.
    task automatic cyc(input logic we, input logic re, input logic [15:0] d);
        logic wa;
        logic ra;
        wr_en   = we;
        rd_en   = re;
        data_in = d;
        wa = we && (mq.size() < 16);
        ra = re && (mq.size() > 0);
        if (we && mq.size() == 16) eov = 1'b1;
        if (re && mq.size() == 0) euf = 1'b1;
        if (ra) begin
            sb.push_back(mq.pop_front());
            erp = erp + 5'd1;
        end
        if (wa) begin
            mq.push_back(d);
            ewp = ewp + 5'd1;
        end
        @(posedge wr_clk);
        #1;
        if (ra) last_out = sb.pop_front();
        chk("data_out", {16'h0, data_out}, {16'h0, last_out});
        chk("wr_ptr", {27'h0, wr_ptr}, {27'h0, ewp});
        chk("rd_ptr", {27'h0, rd_ptr}, {27'h0, erp});
        chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
        chk("full", {31'h0, full}, {31'h0, mq.size() == 16});
`ifdef FIFO16_ERR_FLAGS_EN
        chk("overflow", {31'h0, overflow}, {31'h0, eov});
        chk("underflow", {31'h0, underflow}, {31'h0, euf});
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        mq.delete();
        sb.delete();
        ewp = '0; erp = '0; last_out = '0; eov = 1'b0; euf = 1'b0;
        chk("rst_wr_ptr", {27'h0, wr_ptr}, 32'h0);
        chk("rst_rd_ptr", {27'h0, rd_ptr}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_data_out", {16'h0, data_out}, 32'h0);
`ifdef FIFO16_ERR_FLAGS_EN
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_underflow", {31'h0, underflow}, 32'h0);
`endif
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  occ;
        logic [4:0]  prev_rp;
        logic        wrapped;
        logic        seen_full;
        logic [15:0] hold;
        int          guard;

        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        ewp = '0; erp = '0; last_out = '0; eov = 1'b0; euf = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 5'd1, 5'd0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 5'd2, 5'd0, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd2, 5'd1, 16'h1111};
        tbl[3] = '{1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 5'd3, 5'd2, 16'h2222};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5'd3, 5'd3, 16'h3333};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5'd3, 5'd3, 16'h3333};
        tbl[6] = '{1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 5'd4, 5'd3, 16'h3333};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5'd4, 5'd4, 16'h4444};

        #7;
        chk("init_empty", {31'h0, empty}, 32'h1);
        chk("init_full", {31'h0, full}, 32'h0);
        chk("init_wr_ptr", {27'h0, wr_ptr}, 32'h0);
        chk("init_data_out", {16'h0, data_out}, 32'h0);
        #5;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk("vec_empty", {31'h0, empty}, {31'h0, tbl[i].emp});
            chk("vec_full", {31'h0, full}, {31'h0, tbl[i].ful});
            chk("vec_wr_ptr", {27'h0, wr_ptr}, {27'h0, tbl[i].wp});
            chk("vec_rd_ptr", {27'h0, rd_ptr}, {27'h0, tbl[i].rp});
            chk("vec_data_out", {16'h0, data_out}, {16'h0, tbl[i].dout});
        end

        // Reset with five entries queued and a non-zero data_out.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0A00 + 16'(i));
        cyc(1'b0, 1'b1, 16'h0);
        chk("pre_reset_data_out", {16'h0, data_out}, 32'h0A00);
        do_reset();

        // Fill, overfill, drain, extra read.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 16'(i));
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_wr_ptr", {27'h0, wr_ptr}, 32'h10);
        cyc(1'b1, 1'b0, 16'h0011);
        chk("overfill_wr_ptr", {27'h0, wr_ptr}, 32'h10);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 16'h0);
            chk("drain_data", {16'h0, data_out}, i);
        end
        chk("drain_empty", {31'h0, empty}, 32'h1);
        chk("drain_rd_ptr", {27'h0, rd_ptr}, 32'h10);
        cyc(1'b0, 1'b1, 16'h0);
        chk("extra_read_data", {16'h0, data_out}, 32'h10);

        // Producer every clock, consumer every fourth clock.
        seen_full = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 16) chk("full_at_drop", {31'h0, full}, 32'h1);
            cyc(1'b1, (i % 4) == 3, 16'h0100 + 16'(i));
            if (full) seen_full = 1'b1;
        end
        chk("rate_reached_full", {31'h0, seen_full}, 32'h1);
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            cyc(1'b0, 1'b1, 16'h0);
            guard++;
        end
        chk("rate_drained", {31'h0, empty}, 32'h1);

        // Steady-state simultaneous traffic at occupancy 8, long enough to wrap the pointers.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'h2000 + 16'(i));
        wrapped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_rp = rd_ptr;
            cyc(1'b1, 1'b1, 16'h2100 + 16'(i));
            occ = wr_ptr - rd_ptr;
            chk("simul_occupancy", {27'h0, occ}, 32'h8);
            if (rd_ptr < prev_rp) wrapped = 1'b1;
        end
        chk("simul_wrapped", {31'h0, wrapped}, 32'h1);

        // Both requests at the full and empty boundaries.
        guard = 0;
        while (mq.size() < 16 && guard < 20) begin
            cyc(1'b1, 1'b0, 16'h3000 + 16'(guard));
            guard++;
        end
        cyc(1'b1, 1'b1, 16'hAAAA);
        occ = wr_ptr - rd_ptr;
        chk("full_both_occupancy", {27'h0, occ}, 32'hF);
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            cyc(1'b0, 1'b1, 16'h0);
            guard++;
        end
        hold = data_out;
        cyc(1'b1, 1'b1, 16'hBBBB);
        occ = wr_ptr - rd_ptr;
        chk("empty_both_occupancy", {27'h0, occ}, 32'h1);
        chk("empty_both_data_out", {16'h0, data_out}, {16'h0, hold});
`ifdef FIFO16_ERR_FLAGS_EN
        cyc(1'b0, 1'b0, 16'h0);
        chk("overflow_sticky", {31'h0, overflow}, 32'h1);
        chk("underflow_sticky", {31'h0, underflow}, 32'h1);
`endif
        cyc(1'b0, 1'b1, 16'h0);
        chk("last_word", {16'h0, data_out}, 32'hBBBB);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
